// File: rtl/report_collector_c4.sv
// Report collector for cluster-4 stage 0: timestamps cycles that carry any report bit
// and queues them in a show-ahead FIFO drained over valid/ready, with drop accounting.
module report_collector_c4 #(
    parameter int N_REPORTS = 28,
    parameter int TS_W      = 32,
    parameter int DEPTH     = 16,
    parameter int DROP_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   stream_rst,
    input  logic [7:0]             in_symbol,
    input  logic [N_REPORTS-1:0]   in_reports,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [TS_W-1:0]        ev_ts,
    output logic [N_REPORTS-1:0]   ev_reports,
    output logic [7:0]             ev_symbol,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = TS_W + N_REPORTS + 8;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              c_valid_q, c_valid_d;
    logic [EW-1:0]     c_data_q, c_data_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [EW-1:0]     head_q, head_d;
    logic              ev_valid_q, ev_valid_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic full, pop, offer, push, drop;

    always_comb begin
        ts_d       = ts_q;
        c_valid_d  = 1'b0;
        c_data_d   = c_data_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        head_d     = '0;

        if (stream_rst)
            ts_d = '0;
        else if (run)
            ts_d = ts_q + TS_W'(1);

        if (run && (|in_reports) && !stream_rst) begin
            c_valid_d = 1'b1;
            c_data_d  = {ts_q, in_reports, in_symbol};
        end

        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop   = ev_valid_q && ev_ready;
        // a restart discards the capture still waiting in the C stage
        offer = c_valid_q && !stream_rst;
        push  = offer && (!full || pop);
        drop  = offer && !push;

        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1)
                drop_d = drop_q + DROP_W'(1);
        end

        // next head: the slot being written this edge is not yet in mem_q
        ev_valid_d = (wr_d != rd_d);
        if (ev_valid_d) begin
            if (push && (rd_d == wr_q))
                head_d = c_data_q;
            else
                head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            c_valid_q  <= 1'b0;
            c_data_q   <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            head_q     <= '0;
            ev_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            c_valid_q  <= c_valid_d;
            c_data_q   <= c_data_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            head_q     <= head_d;
            ev_valid_q <= ev_valid_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= c_data_q;
    end

    assign ev_valid   = ev_valid_q;
    assign ev_ts      = head_q[EW-1 -: TS_W];
    assign ev_reports = head_q[N_REPORTS+7 -: N_REPORTS];
    assign ev_symbol  = head_q[7:0];
    assign fifo_level = wr_q - rd_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_report_collector_c4.sv
// Scoreboard bench for report_collector_c4 with narrow timestamp and drop counter
// so that wrap-around and saturation are reached quickly.
module tb_report_collector_c4;
    localparam int N     = 28;
    localparam int TW    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int EW    = TW + N + 8;
    localparam int DMAX  = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          stream_rst = 1'b0;
    logic [7:0]    in_symbol = '0;
    logic [N-1:0]  in_reports = '0;
    logic          ev_ready = 1'b0;
    logic          ev_valid;
    logic [TW-1:0] ev_ts;
    logic [N-1:0]  ev_reports;
    logic [7:0]    ev_symbol;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [DW-1:0] drop_count;

    report_collector_c4 #(
        .N_REPORTS(N),
        .TS_W(TW),
        .DEPTH(DEPTH),
        .DROP_W(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .stream_rst(stream_rst),
        .in_symbol(in_symbol),
        .in_reports(in_reports),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_ts(ev_ts),
        .ev_reports(ev_reports),
        .ev_symbol(ev_symbol),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state: run-cycle counter, pending event, expected event queue
    int            m_ts;
    bit            m_pv;
    logic [EW-1:0] m_pend;
    logic [EW-1:0] exp_q[$];
    bit            m_ovf;
    int            m_drops;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // monitor: sampled mid-low-phase, when inputs for the next edge are stable
    always @(negedge clk) begin
        logic [EW-1:0] head;
        #2;
        if (!reset) begin
            m_ts = 0; m_pv = 0; m_pend = '0; m_ovf = 0; m_drops = 0;
            exp_q.delete();
        end
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("ev_valid",   64'(ev_valid),   64'(exp_q.size() != 0));
        chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        chk("overflow",   64'(overflow),   64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        chk("ev_ts",      64'(ev_ts),      64'(head[EW-1 -: TW]));
        chk("ev_reports", 64'(ev_reports), 64'(head[N+7 -: N]));
        chk("ev_symbol",  64'(ev_symbol),  64'(head[7:0]));
        if (reset) begin
            if (exp_q.size() > 0 && ev_ready)
                void'(exp_q.pop_front());
            if (m_pv && !stream_rst) begin
                if (exp_q.size() < DEPTH)
                    exp_q.push_back(m_pend);
                else begin
                    m_ovf = 1;
                    if (m_drops < DMAX) m_drops++;
                end
            end
            m_pv   = run && (in_reports != 0) && !stream_rst;
            m_pend = {TW'(m_ts), in_reports, in_symbol};
            if (stream_rst)  m_ts = 0;
            else if (run)    m_ts = (m_ts + 1) % (1 << TW);
        end
    end

    task automatic cyc(input logic r, input logic s, input logic [N-1:0] rep,
                       input logic [7:0] sym, input logic rdy);
        @(negedge clk);
        run = r; stream_rst = s; in_reports = rep; in_symbol = sym; ev_ready = rdy;
    endtask

    function automatic logic [N-1:0] rnd_rep();
        logic [N-1:0] v;
        v = N'($urandom);
        if (v == 0) v = N'(1);
        return v;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // 1: first event after 5 idle run cycles carries ts=5
        repeat (5) cyc(1, 0, '0, 8'h00, 1);
        cyc(1, 0, 28'h0000010, 8'hA5, 1);
        cyc(1, 0, '0, 8'h00, 1);
        #3 chk("t1_not_yet", 64'(ev_valid), 64'd0);
        cyc(1, 0, '0, 8'h00, 1);
        #3 chk("t1_valid", 64'(ev_valid), 64'd1);
        chk("t1_ts", 64'(ev_ts), 64'd5);
        chk("t1_sym", 64'(ev_symbol), 64'hA5);
        repeat (3) cyc(1, 0, '0, 8'h00, 1);
        #3 chk("t1_level", 64'(fifo_level), 64'd0);

        // 2: backpressure, 19 reports into 16 slots
        for (int i = 0; i < 19; i++) cyc(1, 0, rnd_rep(), 8'(i), 0);
        cyc(1, 0, '0, 8'h00, 0);
        cyc(1, 0, '0, 8'h00, 0);
        #3 chk("t2_level", 64'(fifo_level), 64'd16);
        chk("t2_ovf", 64'(overflow), 64'd1);
        chk("t2_drops", 64'(drop_count), 64'd3);

        // 3: full, pending push coincides with a pop
        cyc(1, 0, 28'h0ABCDEF, 8'h3C, 0);
        cyc(1, 0, '0, 8'h00, 1);
        cyc(1, 0, '0, 8'h00, 0);
        #3 chk("t3_level", 64'(fifo_level), 64'd16);
        repeat (20) cyc(1, 0, '0, 8'h00, 1);

        // 4: run gating with reports held
        for (int i = 0; i < 9; i++) cyc(((i % 2) == 0), 0, 28'h8000001, 8'h77, 1);
        repeat (4) cyc(1, 0, '0, 8'h00, 1);

        // 5: restart discards the pending capture, queued entries survive
        for (int i = 0; i < 3; i++) cyc(1, 0, rnd_rep(), 8'h50 + 8'(i), 0);
        cyc(1, 1, rnd_rep(), 8'h60, 0);
        cyc(1, 0, 28'h0000003, 8'h61, 0);
        cyc(1, 0, '0, 8'h00, 0);
        repeat (3) cyc(1, 0, '0, 8'h00, 1);
        cyc(1, 0, rnd_rep(), 8'h62, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("t5_rst_valid", 64'(ev_valid), 64'd0);
        chk("t5_rst_level", 64'(fifo_level), 64'd0);
        chk("t5_rst_ovf", 64'(overflow), 64'd0);
        chk("t5_rst_ts", 64'(ev_ts), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // 6: timestamp wrap, then drop counter saturation
        for (int i = 0; i < 20; i++) cyc(1, 0, rnd_rep(), 8'(i), 1);
        for (int i = 0; i < 25; i++) cyc(1, 0, rnd_rep(), 8'(i), 0);
        cyc(1, 0, '0, 8'h00, 0);
        cyc(1, 0, '0, 8'h00, 0);
        #3 chk("t6_drops_sat", 64'(drop_count), 64'(DMAX));
        chk("t6_ovf", 64'(overflow), 64'd1);
        repeat (20) cyc(1, 0, '0, 8'h00, 1);

        // random mix
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(3) != 0), ($urandom_range(31) == 0),
                ($urandom_range(1) != 0) ? rnd_rep() : '0, 8'($urandom),
                ($urandom_range(4) < 3));
        repeat (25) cyc(1, 0, '0, 8'h00, 1);
        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
